// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: word-aligned valid/ready data bus access,
// load alignment, pipeline stall control and the M->W pipeline register.
module mem_stage_lsu #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memRead_M,
    input  logic        memWrite_M,
    input  logic        regWrite_M,
    input  logic [2:0]  resultScr_M,
    input  logic [2:0]  mode_M,
    input  logic [31:0] ALURuslt_M,
    input  logic [31:0] write_Data_M,
    input  logic [31:0] imm_extended_M,
    input  logic [31:0] pc4_M,
    input  logic [31:0] PC_target_mux_M,
    input  logic [4:0]  rd_M,
    output logic        stall_M,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        regWrite_W,
    output logic [2:0]  resultScr_W,
    output logic [31:0] ALURuslt_W,
    output logic [31:0] readData_W,
    output logic [31:0] imm_extended_W,
    output logic [31:0] pc4_W,
    output logic [31:0] PC_target_W,
    output logic [4:0]  rd_W,
    output logic        misalign_W,
    output logic        bus_err_W
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             expired;
    logic [2:0]       mode_q;
    logic [1:0]       off_q;
    logic [31:0]      rdata_q;
    logic             err_q;
    logic             access;
    logic             mis;
    logic             launch;
    logic [3:0]       wstrb_d;
    logic [31:0]      wdata_d;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      rdata_al;

    assign access = memRead_M | memWrite_M;
    assign mis = ((mode_M[1:0] == 2'b01) & ALURuslt_M[0])
               | ((mode_M[1:0] == 2'b10) & (ALURuslt_M[1:0] != 2'b00))
               | (mode_M == 3'b011)
               | (mode_M[2:1] == 2'b11);
    assign launch = (state == IDLE) & access & ~mis;

    // Stall is gated by reset so a held access cannot freeze the pipe in reset
    assign stall_M = rst_n & (launch | (state == REQ) | (state == RESP));
    assign mem_req = (state == REQ);

    assign cnt_nxt = cnt + 1'b1;
    assign expired = (cnt_nxt == CNT_W'(TIMEOUT));

    always_comb begin
        wstrb_d = 4'b1111;
        wdata_d = write_Data_M;
        case (mode_M[1:0])
            2'b00: begin
                wstrb_d = 4'b0001 << ALURuslt_M[1:0];
                wdata_d = {4{write_Data_M[7:0]}};
            end
            2'b01: begin
                wstrb_d = ALURuslt_M[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{write_Data_M[15:0]}};
            end
            default: ;
        endcase
    end

    assign byte_sel = mem_rdata[{off_q, 3'b000} +: 8];
    assign half_sel = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        rdata_al = mem_rdata;
        case (mode_q)
            3'b000:  rdata_al = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  rdata_al = {24'h0, byte_sel};
            3'b001:  rdata_al = {{16{half_sel[15]}}, half_sel};
            3'b101:  rdata_al = {16'h0, half_sel};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            mode_q    <= '0;
            off_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        state     <= REQ;
                        cnt       <= '0;
                        mem_we    <= memWrite_M;
                        mem_addr  <= {ALURuslt_M[31:2], 2'b00};
                        mem_wdata <= wdata_d;
                        mem_wstrb <= memWrite_M ? wstrb_d : 4'b0000;
                        mode_q    <= mode_M;
                        off_q     <= ALURuslt_M[1:0];
                        rdata_q   <= '0;
                        err_q     <= 1'b0;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        state <= mem_we ? DONE : RESP;
                        cnt   <= '0;
                    end else if (expired) begin
                        state <= DONE;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        state   <= DONE;
                        rdata_q <= rdata_al;
                    end else if (expired) begin
                        state <= DONE;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWrite_W     <= 1'b0;
            resultScr_W    <= '0;
            ALURuslt_W     <= '0;
            readData_W     <= '0;
            imm_extended_W <= '0;
            pc4_W          <= '0;
            PC_target_W    <= '0;
            rd_W           <= '0;
            misalign_W     <= 1'b0;
            bus_err_W      <= 1'b0;
        end else if (stall_M) begin
            regWrite_W     <= 1'b0;
            resultScr_W    <= '0;
            ALURuslt_W     <= '0;
            readData_W     <= '0;
            imm_extended_W <= '0;
            pc4_W          <= '0;
            PC_target_W    <= '0;
            rd_W           <= '0;
            misalign_W     <= 1'b0;
            bus_err_W      <= 1'b0;
        end else begin
            resultScr_W    <= resultScr_M;
            ALURuslt_W     <= ALURuslt_M;
            imm_extended_W <= imm_extended_M;
            pc4_W          <= pc4_M;
            PC_target_W    <= PC_target_mux_M;
            rd_W           <= rd_M;
            if (state == DONE) begin
                regWrite_W <= regWrite_M & ~err_q;
                readData_W <= rdata_q;
                misalign_W <= 1'b0;
                bus_err_W  <= err_q;
            end else begin
                regWrite_W <= regWrite_M & ~(access & mis);
                readData_W <= '0;
                misalign_W <= access & mis;
                bus_err_W  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a cycle-plan model per instruction
// plus pinned literal values at chosen cycles.
module tb_mem_stage_lsu;
    localparam int TO = 4;

    localparam int S_RDATA = 0;
    localparam int S_WDATA = 1;
    localparam int S_ADDR  = 2;
    localparam int S_WSTRB = 3;
    localparam int S_REQ   = 4;
    localparam int S_STALL = 5;
    localparam int S_RW    = 6;
    localparam int S_RD    = 7;
    localparam int S_ALU   = 8;
    localparam int S_ERR   = 9;
    localparam int S_MIS   = 10;
    localparam int S_WE    = 11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memRead_M, memWrite_M, regWrite_M;
    logic [2:0]  resultScr_M, mode_M;
    logic [31:0] ALURuslt_M, write_Data_M, imm_extended_M;
    logic [31:0] pc4_M, PC_target_mux_M;
    logic [4:0]  rd_M;
    logic        stall_M, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        regWrite_W;
    logic [2:0]  resultScr_W;
    logic [31:0] ALURuslt_W, readData_W, imm_extended_W;
    logic [31:0] pc4_W, PC_target_W;
    logic [4:0]  rd_W;
    logic        misalign_W, bus_err_W;

    mem_stage_lsu #(.TIMEOUT(TO), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .memRead_M(memRead_M), .memWrite_M(memWrite_M),
        .regWrite_M(regWrite_M), .resultScr_M(resultScr_M),
        .mode_M(mode_M), .ALURuslt_M(ALURuslt_M),
        .write_Data_M(write_Data_M),
        .imm_extended_M(imm_extended_M), .pc4_M(pc4_M),
        .PC_target_mux_M(PC_target_mux_M), .rd_M(rd_M),
        .stall_M(stall_M), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .regWrite_W(regWrite_W), .resultScr_W(resultScr_W),
        .ALURuslt_W(ALURuslt_W), .readData_W(readData_W),
        .imm_extended_W(imm_extended_W), .pc4_W(pc4_W),
        .PC_target_W(PC_target_W), .rd_W(rd_W),
        .misalign_W(misalign_W), .bus_err_W(bus_err_W)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bubble;
        logic        rw;
        logic [2:0]  rs;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [31:0] pct;
        logic        mis;
        logic        err;
    } wexp_t;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    bit w_valid = 1'b0;

    logic        exp_stall, exp_req, exp_store;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    wexp_t       w_next, exp_w;

    int          lit_n = 0;
    int          lit_at[64];
    int          lit_sig[64];
    logic [31:0] lit_val[64];
    string       lit_nm[64];

    function automatic logic [31:0] read_sig(input int s);
        case (s)
            S_RDATA: return readData_W;
            S_WDATA: return mem_wdata;
            S_ADDR:  return mem_addr;
            S_WSTRB: return 32'(mem_wstrb);
            S_REQ:   return 32'(mem_req);
            S_STALL: return 32'(stall_M);
            S_RW:    return 32'(regWrite_W);
            S_RD:    return 32'(rd_W);
            S_ALU:   return ALURuslt_W;
            S_ERR:   return 32'(bus_err_W);
            S_MIS:   return 32'(misalign_W);
            S_WE:    return 32'(mem_we);
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got %h expected %h",
                     nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < lit_n; i++)
            if (lit_at[i] == cyc)
                check(lit_nm[i], read_sig(lit_sig[i]), lit_val[i]);
        if (!chk_en) begin
            w_valid = 1'b0;
        end else begin
            check("stall_M", 32'(stall_M), 32'(exp_stall));
            check("mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req) begin
                check("mem_we", 32'(mem_we), 32'(exp_store));
                check("mem_addr", mem_addr, exp_addr);
                if (exp_store) begin
                    check("mem_wdata", mem_wdata, exp_wdata);
                    check("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
                end
            end
            if (w_valid) begin
                check("regWrite_W", 32'(regWrite_W), 32'(exp_w.rw));
                check("rd_W", 32'(rd_W), 32'(exp_w.rd));
                check("misalign_W", 32'(misalign_W), 32'(exp_w.mis));
                check("bus_err_W", 32'(bus_err_W), 32'(exp_w.err));
                if (!exp_w.bubble) begin
                    check("resultScr_W", 32'(resultScr_W), 32'(exp_w.rs));
                    check("ALURuslt_W", ALURuslt_W, exp_w.alu);
                    check("readData_W", readData_W, exp_w.rdata);
                    check("imm_W", imm_extended_W, exp_w.imm);
                    check("pc4_W", pc4_W, exp_w.pc4);
                    check("PC_target_W", PC_target_W, exp_w.pct);
                end
            end
            exp_w = w_next;
            w_valid = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input int at, input int s,
                       input logic [31:0] v);
        lit_nm[lit_n] = nm;
        lit_at[lit_n] = at;
        lit_sig[lit_n] = s;
        lit_val[lit_n] = v;
        lit_n++;
    endtask

    task automatic set_m(input logic rd_en, input logic wr_en,
                         input logic rw, input logic [2:0] mode,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd);
        memRead_M       = rd_en;
        memWrite_M      = wr_en;
        regWrite_M      = rw;
        mode_M          = mode;
        ALURuslt_M      = addr;
        write_Data_M    = wd;
        rd_M            = rd;
        resultScr_M     = rd_en ? 3'd1 : 3'd0;
        imm_extended_M  = addr ^ 32'h0F0F_0000;
        pc4_M           = 32'h0000_8000 + 32'(cyc * 4);
        PC_target_mux_M = 32'h0001_0000 + addr;
    endtask

    task automatic one_cycle(input bit st, input bit rq, input bit g,
                             input bit rv, input logic [31:0] rdv,
                             input wexp_t wn);
        cyc++;
        exp_stall  = st;
        exp_req    = rq;
        mem_gnt    = g;
        mem_rvalid = rv;
        mem_rdata  = rdv;
        w_next     = wn;
        step();
    endtask

    // gdly: REQ cycles before gnt (-1 never); rdly: cycles after gnt
    // until rvalid (-1 never); early_rv: junk rvalid on the gnt cycle.
    task automatic run_instr(input int gdly, input int rdly,
                             input logic [31:0] rdata, input bit early_rv);
        bit          acc, mis, tmo;
        int          sz, nb, off, nreq, nresp;
        logic [31:0] lv, mask, wd;
        wexp_t       ret, bub;
        acc  = memRead_M || memWrite_M;
        sz   = int'(mode_M[1:0]);
        nb   = 1 << sz;
        off  = int'(ALURuslt_M[1:0]);
        mis  = (sz == 1 && off % 2 != 0) || (sz == 2 && off != 0)
            || mode_M == 3'b011 || mode_M == 3'b110 || mode_M == 3'b111;
        for (int i = 0; i < 4; i++)
            wd[8*i +: 8] = write_Data_M[8*(i % nb) +: 8];
        exp_store = memWrite_M;
        exp_addr  = ALURuslt_M & ~32'h3;
        exp_wdata = wd;
        exp_wstrb = 4'(((1 << nb) - 1) << off);
        mask = (nb >= 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * nb)) - 1;
        lv = (rdata >> (8 * off)) & mask;
        if (!mode_M[2] && nb < 4 && lv[8*nb-1]) lv = lv | ~mask;
        bub = '{1'b1, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                32'd0, 1'b0, 1'b0};
        ret = '{1'b0, regWrite_M && !(acc && mis), resultScr_M, rd_M,
                ALURuslt_M, 32'd0, imm_extended_M, pc4_M,
                PC_target_mux_M, acc && mis, 1'b0};
        if (!acc || mis) begin
            one_cycle(0, 0, 0, early_rv, 32'hBAD0_BAD0, ret);
        end else begin
            tmo = 1'b0;
            one_cycle(1, 0, 0, 0, 32'd0, bub);
            nreq = (gdly < 0 || gdly >= TO) ? TO : gdly + 1;
            for (int j = 0; j < nreq; j++)
                one_cycle(1, 1, j == gdly, early_rv && j == gdly,
                          32'hDEAD_BEEF, bub);
            if (gdly < 0 || gdly >= TO) begin
                tmo = 1'b1;
            end else if (memRead_M) begin
                nresp = (rdly < 1 || rdly > TO) ? TO : rdly;
                for (int k = 1; k <= nresp; k++)
                    one_cycle(1, 0, 0, k == rdly, rdata, bub);
                if (rdly < 1 || rdly > TO) tmo = 1'b1;
                else ret.rdata = lv;
            end
            if (tmo) begin
                ret.err = 1'b1;
                ret.rw = 1'b0;
                ret.rdata = 32'd0;
            end
            one_cycle(0, 0, 0, 0, 32'd0, ret);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata = 32'd0;
        set_m(1, 0, 1, 3'b010, 32'h40, 32'd0, 5'd3);
        step();
        cyc++;
        lit("rst_req", cyc, S_REQ, 0);
        lit("rst_stall", cyc, S_STALL, 0);
        lit("rst_addr", cyc, S_ADDR, 0);
        lit("rst_wstrb", cyc, S_WSTRB, 0);
        lit("rst_rw", cyc, S_RW, 0);
        lit("rst_rdw", cyc, S_RD, 0);
        lit("rst_alu", cyc, S_ALU, 0);
        step();
        rst_n = 1'b1;
        chk_en = 1'b1;

        set_m(0, 0, 1, 3'b010, 32'h1234, 32'd0, 5'd5);
        run_instr(0, 0, 32'd0, 0);
        lit("alu_rw", cyc + 1, S_RW, 1);
        lit("alu_rd", cyc + 1, S_RD, 5);
        lit("alu_res", cyc + 1, S_ALU, 32'h1234);

        set_m(0, 1, 0, 3'b000, 32'h1003, 32'hAABB_CCDD, 5'd0);
        lit("sb_addr", cyc + 2, S_ADDR, 32'h1000);
        lit("sb_wstrb", cyc + 2, S_WSTRB, 32'h8);
        lit("sb_wdata", cyc + 2, S_WDATA, 32'hDDDD_DDDD);
        lit("sb_we", cyc + 2, S_WE, 1);
        lit("sb_stall3", cyc + 3, S_STALL, 1);
        lit("sb_done", cyc + 4, S_STALL, 0);
        run_instr(1, -1, 32'd0, 0);
        lit("sb_rw", cyc + 1, S_RW, 0);

        set_m(1, 0, 1, 3'b001, 32'h2002, 32'd0, 5'd10);
        run_instr(0, 2, 32'h8001_7FFF, 0);
        lit("lh_data", cyc + 1, S_RDATA, 32'hFFFF_8001);

        set_m(1, 0, 1, 3'b101, 32'h2002, 32'd0, 5'd10);
        run_instr(0, 2, 32'h8001_7FFF, 1);
        lit("lhu_data", cyc + 1, S_RDATA, 32'h0000_8001);

        set_m(1, 0, 1, 3'b010, 32'h3002, 32'd0, 5'd11);
        lit("mis_req", cyc + 1, S_REQ, 0);
        run_instr(0, 1, 32'd0, 0);
        lit("mis_flag", cyc + 1, S_MIS, 1);
        lit("mis_rw", cyc + 1, S_RW, 0);

        set_m(1, 0, 1, 3'b010, 32'h3000, 32'd0, 5'd9);
        lit("to_req4", cyc + 5, S_REQ, 1);
        lit("to_req_drop", cyc + 6, S_REQ, 0);
        run_instr(-1, -1, 32'd0, 0);
        lit("to_err", cyc + 1, S_ERR, 1);
        lit("to_rw", cyc + 1, S_RW, 0);

        set_m(0, 0, 1, 3'b000, 32'h55, 32'd0, 5'd4);
        run_instr(0, 0, 32'd0, 0);

        set_m(1, 0, 1, 3'b000, 32'h5001, 32'd0, 5'd12);
        run_instr(0, 1, 32'h0000_8000, 0);
        lit("lb_data", cyc + 1, S_RDATA, 32'hFFFF_FF80);

        set_m(1, 0, 1, 3'b100, 32'h5003, 32'd0, 5'd13);
        run_instr(2, 3, 32'h7F00_0000, 0);
        lit("lbu_data", cyc + 1, S_RDATA, 32'h0000_007F);

        set_m(0, 1, 0, 3'b001, 32'h6002, 32'h1234_ABCD, 5'd0);
        lit("sh_wstrb", cyc + 2, S_WSTRB, 32'hC);
        lit("sh_wdata", cyc + 2, S_WDATA, 32'hABCD_ABCD);
        run_instr(0, -1, 32'd0, 0);

        set_m(0, 1, 0, 3'b010, 32'h6004, 32'h8765_4321, 5'd0);
        run_instr(3, -1, 32'd0, 0);

        set_m(1, 0, 1, 3'b010, 32'h7008, 32'd0, 5'd14);
        run_instr(0, 1, 32'hCAFE_F00D, 0);
        lit("lw_data", cyc + 1, S_RDATA, 32'hCAFE_F00D);

        set_m(1, 0, 1, 3'b010, 32'h700C, 32'd0, 5'd15);
        run_instr(0, -1, 32'd0, 0);
        lit("resp_to_err", cyc + 1, S_ERR, 1);

        set_m(0, 0, 1, 3'b010, 32'h77, 32'd0, 5'd6);
        run_instr(0, 0, 32'd0, 1);

        set_m(0, 1, 0, 3'b001, 32'h6001, 32'h0000_1111, 5'd0);
        run_instr(0, 0, 32'd0, 0);
        lit("shmis_flag", cyc + 1, S_MIS, 1);

        set_m(1, 0, 1, 3'b011, 32'h100, 32'd0, 5'd16);
        run_instr(0, 1, 32'd0, 0);
        lit("m3_flag", cyc + 1, S_MIS, 1);
        lit("m3_rw", cyc + 1, S_RW, 0);

        set_m(0, 0, 0, 3'b010, 32'h0, 32'd0, 5'd0);
        run_instr(0, 0, 32'd0, 0);

        chk_en = 1'b0;
        set_m(1, 0, 1, 3'b010, 32'h4000, 32'd0, 5'd7);
        cyc++;
        mem_gnt = 1'b0;
        step();
        cyc++;
        mem_gnt = 1'b1;
        step();
        cyc++;
        mem_gnt = 1'b0;
        lit("pre_rst_req", cyc, S_REQ, 0);
        lit("pre_rst_stall", cyc, S_STALL, 1);
        step();
        cyc++;
        rst_n = 1'b0;
        lit("mid_rst_req", cyc, S_REQ, 0);
        lit("mid_rst_stall", cyc, S_STALL, 0);
        lit("mid_rst_rw", cyc, S_RW, 0);
        lit("mid_rst_rd", cyc, S_RD, 0);
        lit("mid_rst_alu", cyc, S_ALU, 0);
        lit("mid_rst_data", cyc, S_RDATA, 0);
        step();
        rst_n = 1'b1;
        chk_en = 1'b1;
        run_instr(0, 1, 32'h1122_3344, 0);
        lit("rerun_data", cyc + 1, S_RDATA, 32'h1122_3344);

        set_m(0, 0, 1, 3'b010, 32'h99, 32'd0, 5'd8);
        run_instr(0, 0, 32'd0, 0);
        set_m(0, 0, 0, 3'b010, 32'h0, 32'd0, 5'd0);
        run_instr(0, 0, 32'd0, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. It consumes the M-side outputs of the EX stage (memRead_M, memWrite_M, mode_M, ALURuslt_M, write_Data_M, and related signals).
- It runs a word-aligned valid/ready transaction on the data-memory bus and aligns load data with sign or zero extension.
- It stalls the pipeline while a bus access is outstanding and holds the M→W pipeline register.
- It sits between the EX stage's M register and the write-back mux.

Parameters:
- TIMEOUT, 255: maximum cycles to wait in REQ or RESP before the access is aborted with an error.
- CNT_W, 8: width of the timeout counter. Must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- memRead_M, memWrite_M, regWrite_M  in  1  M-stage controls (read and write are never both 1)
- resultScr_M  in  3  write-back select
- mode_M  in  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- ALURuslt_M, write_Data_M, imm_extended_M, pc4_M, PC_target_mux_M  in  32  M-stage data
- rd_M  in  5  destination register
- stall_M  out  1  freeze PC/F/D/E/M registers
- mem_req  out  1  bus request valid
- mem_we  out  1  1 = store
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_wdata  out  32  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_gnt  in  1  bus accepted request (ready)
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load word
- regWrite_W  out  1  W-stage write enable
- resultScr_W  out  3  W-stage result select
- ALURuslt_W, readData_W, imm_extended_W, pc4_W, PC_target_W  out  32  W-stage data
- rd_W  out  5  W-stage destination register
- misalign_W, bus_err_W  out  1  exception flags for the instruction in W

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE and the counter clears.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0.
  - All W outputs are 0. stall_M=0.
- Address decode:
  - access = memRead_M | memWrite_M.
  - mis = (halfword & addr[0]) | (word & addr[1:0]≠0) | mode ∈ {011,110,111}.
- Store lanes:
  - SB: wstrb = 0001 << addr[1:0]; wdata = {4{wd[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011; wdata = {2{wd[15:0]}}.
  - SW: wstrb = 1111; wdata = wd.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE, access & ~mis: latch the bus fields and go to REQ. stall_M=1 (combinational).
  - IDLE, access & mis: no bus activity and stall_M=0. The instruction passes to W with misalign_W=1. A misaligned store writes nothing. A misaligned load gets readData_W=0 and regWrite_W=0.
  - IDLE, no access: stall_M=0 and the pipeline flows.
  - REQ: mem_req=1, with fields stable until the cycle mem_gnt=1. On gnt, a store goes to DONE and a load goes to RESP. stall_M=1.
  - RESP: mem_req=0. On mem_rvalid=1, capture the aligned rdata and go to DONE. stall_M=1. An rvalid arriving in the same cycle as gnt is ignored; the response must arrive in a later cycle.
  - DONE: stall_M=0 for exactly one cycle. The W register captures the instruction with the captured load data, then the FSM returns to IDLE. The next M instruction is evaluated in IDLE on the following cycle, so there is no re-issue.
- Timeout:
  - The counter clears on entry to REQ or RESP and increments each cycle there.
  - At count == TIMEOUT, drop mem_req, set the bus_err flag, force regWrite to 0, and go to DONE.
  - A later stray rvalid is ignored.
- Load alignment:
  - Select the byte at addr[1:0] or the half at addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- W register:
  - Loads on every rising edge.
  - If stall_M=1, it loads a bubble: regWrite_W=0, rd_W=0, flags 0, data fields don't-care (held at 0).
  - Otherwise it loads the M inputs plus readData and the flags.
- Reset mid-operation: abandon the transaction immediately. mem_req drops asynchronously.
- Latency:
  - Aligned store: 1 + gnt-wait + 1 stall cycles, minimum 2.
  - Aligned load: minimum 3 stall cycles.
  - Non-memory and misaligned instructions: 0 stall cycles.

Test Plan:
- ALU op (regWrite_M=1, rd_M=5, ALURuslt_M=0x1234) → stall_M=0, no mem_req. The next cycle regWrite_W=1, rd_W=5, ALURuslt_W=0x1234.
- SB, addr 0x1003, wd 0xAABBCCDD, gnt on the 2nd REQ cycle → mem_addr=0x1000, wstrb=1000, wdata=0xDDDDDDDD, mem_we=1. stall_M high for 3 cycles, then the store retires with regWrite_W=0.
- LH, addr 0x2002, rdata 0x8001_7FFF, gnt immediate, rvalid 2 cycles later → readData_W=0xFFFF8001. LHU with the same stimulus → 0x00008001.
- LW, addr 0x3002 → no mem_req and stall_M=0. Next cycle misalign_W=1, regWrite_W=0.
- LW with gnt never asserted, TIMEOUT=4 → mem_req drops after 4 REQ cycles, bus_err_W=1, regWrite_W=0, then the pipeline resumes.
- Load in RESP with rst_n pulsed low → mem_req=0 and all W outputs 0 immediately. After release, IDLE and stall_M follows the current access.
